fwd_hazard_unit: RTL

Parametrised forwarding and load-use hazard unit for the decode stage. It tracks the destination register of every in-flight instruction in its own shift register of pipeline entries. For each source operand in ID, it produces a one-hot bypass select (youngest match wins). It raises a stall when the matching producer's result is not yet forwardable. It sits beside the decoder and drives the operand bypass muxes and the ID/IF hold logic.

---
 rtl/fwd_hazard_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select and load-use stall generation for
// the decode stage. Each in-flight instruction's destination is tracked in a
// shift register (entry 0 = IS, entry NUM_STAGES-1 = WB).
// Optional feature macro: FWD_STALL_CNT_EN builds a saturating 32-bit stall
// cycle counter on stall_cnt_out; otherwise stall_cnt_out is tied to zero.
module fwd_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 5,
  parameter int LATE_STAGE = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_SRC*ADDR_W-1:0]     rs_addr_in,
  input  logic [NUM_SRC-1:0]            rs_used_in,
  input  logic                          id_valid_in,
  input  logic [ADDR_W-1:0]             id_rd_addr_in,
  input  logic                          id_rd_late_in,
  input  logic                          flush_in,
  output logic [NUM_SRC*NUM_STAGES-1:0] fwd_sel_out,
  output logic                          stall_out,
  output logic [31:0]                   stall_cnt_out
);

  logic [NUM_STAGES-1:0]               ent_valid;
  logic [ADDR_W-1:0]                   ent_rd [NUM_STAGES];
  logic [NUM_STAGES-1:0]               ent_late;

  logic [NUM_SRC-1:0][NUM_STAGES-1:0]  young_sel;
  logic [NUM_SRC-1:0]                  hazard;

  // Youngest matching producer per source, and whether its result is not yet forwardable
  always_comb begin
    young_sel = '0;
    hazard    = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      logic found;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        if (!found && rs_used_in[s] &&
            (rs_addr_in[s*ADDR_W +: ADDR_W] != '0) &&
            ent_valid[k] && (ent_rd[k] == rs_addr_in[s*ADDR_W +: ADDR_W])) begin
          found           = 1'b1;
          young_sel[s][k] = 1'b1;
          if (ent_late[k] && (k < unsigned'(LATE_STAGE)))
            hazard[s] = 1'b1;
        end
      end
    end
  end

  // Stall when any source hits an unforwardable producer; flush overrides
  always_comb begin
    stall_out = (|hazard) & id_valid_in & ~flush_in;
  end

  // Bypass selects are suppressed on a hazarded source or while stalling
  always_comb begin
    fwd_sel_out = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (!hazard[s] && !stall_out)
        fwd_sel_out[s*NUM_STAGES +: NUM_STAGES] = young_sel[s];
    end
  end

  // Entry shift register: advances every cycle, stall inserts a bubble at IS
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ent_valid <= '0;
      ent_late  <= '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++)
        ent_rd[k] <= '0;
    end else begin
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_rd[k]    <= ent_rd[k-1];
        ent_late[k]  <= ent_late[k-1];
      end
      // later assignment overrides the loop: a flushed IS instruction dies here
      ent_valid[1] <= ent_valid[0] & ~flush_in;
      ent_valid[0] <= id_valid_in & (id_rd_addr_in != '0) & ~stall_out & ~flush_in;
      ent_rd[0]    <= id_rd_addr_in;
      ent_late[0]  <= id_rd_late_in;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Saturating count of stalled cycles
  always_ff @(posedge clk_in) begin
    if (rst_in)
      stall_cnt <= '0;
    else if (stall_out && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cnt_out = stall_cnt;
`else
  assign stall_cnt_out = '0;
`endif

endmodule
